// File: rtl/demultiplexer_1to8_deser_pkg.sv
// Shared types and widths for the 1-to-8 serial-to-parallel receiver.
// The receiver's three states and the word/index widths live here.
package demultiplexer_1to8_deser_pkg;

    localparam int WORD_W = 8;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

endpackage

// File: rtl/demux_1to8_dec.sv
// Combinational 3-to-8 one-hot write-enable decoder.
// When en is low, all enables are low.
module demux_1to8_dec
    import demultiplexer_1to8_deser_pkg::*;
(
    input  logic [IDX_W-1:0]  sel,
    input  logic              en,
    output logic [WORD_W-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = en;
    end

endmodule

// File: rtl/demultiplexer_1to8_deser.sv
// 1-to-8 deserializer: steers serial bits into an 8-bit word register.
// It holds each completed word until the consumer takes it.
module demultiplexer_1to8_deser
    import demultiplexer_1to8_deser_pkg::*;
#(
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              din_valid,
    input  logic              clear,
    output logic [WORD_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [IDX_W-1:0]  bit_index,
    output logic              busy,
    output logic              overflow
);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                ovf_q, ovf_d;
    logic                accept;
    logic [IDX_W-1:0]    dec_sel;
    logic [WORD_W-1:0]   wr_en;

    // MSB-first order writes position 7-k, which is the bitwise inverse of k.
    assign dec_sel = (MSB_FIRST != 0) ? ~idx_q : idx_q;

    demux_1to8_dec u_dec (
        .sel    (dec_sel),
        .en     (accept),
        .onehot (wr_en)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    idx_d = '0;
                end else if (din_valid) begin
                    accept  = 1'b1;
                    idx_d   = IDX_W'(1);
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (clear) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else if (din_valid) begin
                    accept = 1'b1;
                    if (idx_q == IDX_W'(WORD_W - 1)) begin
                        idx_d   = '0;
                        state_d = FULL;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            FULL: begin
                // A bit arriving during the release becomes bit 0 of the next word.
                if (dout_ready) begin
                    if (din_valid && !clear) begin
                        accept  = 1'b1;
                        idx_d   = IDX_W'(1);
                        state_d = COLLECT;
                    end else begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end else if (din_valid && !clear) begin
                    ovf_d = 1'b1;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Unwritten positions keep their old contents.
    always_comb begin
        word_d = (word_q & ~wr_en) | (wr_en & {WORD_W{din}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dout       = word_q;
    assign dout_valid = (state_q == FULL);
    assign busy       = (state_q == COLLECT);
    assign bit_index  = idx_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_demultiplexer_1to8_deser.sv
// Scoreboard bench: drives LSB-first and MSB-first instances with the same stream.
// It compares their outputs against a queue-based model of the receiver.
module tb_demultiplexer_1to8_deser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       clear = 1'b0;
    logic       dout_ready = 1'b0;

    logic [7:0] dout0, dout1;
    logic       dv0, dv1, busy0, busy1, ov0, ov1;
    logic [2:0] bi0, bi1;

    int n_tests = 0;
    int n_fail  = 0;

    bit         held[$];
    bit         m_full;
    bit         m_ovf;
    logic [7:0] exp_lsb[$];
    logic [7:0] exp_msb[$];

    always #5 clk = ~clk;

    demultiplexer_1to8_deser #(.MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clear(clear),
        .dout(dout0), .dout_valid(dv0), .dout_ready(dout_ready),
        .bit_index(bi0), .busy(busy0), .overflow(ov0)
    );

    demultiplexer_1to8_deser #(.MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clear(clear),
        .dout(dout1), .dout_valid(dv1), .dout_ready(dout_ready),
        .bit_index(bi1), .busy(busy1), .overflow(ov1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        held.delete();
        exp_lsb.delete();
        exp_msb.delete();
        m_full = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic add_bit(input bit b);
        logic [7:0] w0, w1;
        held.push_back(b);
        if (held.size() == 8) begin
            w0 = '0;
            w1 = '0;
            for (int k = 0; k < 8; k++) begin
                w0[k]     = held[k];
                w1[7 - k] = held[k];
            end
            exp_lsb.push_back(w0);
            exp_msb.push_back(w1);
            held.delete();
            m_full = 1'b1;
        end
    endtask

    // Effect of one clock edge with the given inputs, in terms of held bits.
    task automatic model_step(input bit v, input bit b, input bit r, input bit c);
        if (m_full) begin
            if (r) begin
                m_full = 1'b0;
                if (v && !c) add_bit(b);
            end else if (v && !c) begin
                m_ovf = 1'b1;
            end
        end else if (c) begin
            held.delete();
        end else if (v) begin
            add_bit(b);
        end
    endtask

    task automatic check_output();
        check("lsb bit_index", bi0, held.size());
        check("msb bit_index", bi1, held.size());
        check("lsb busy", busy0, held.size() != 0);
        check("msb busy", busy1, held.size() != 0);
        check("lsb dout_valid", dv0, m_full);
        check("msb dout_valid", dv1, m_full);
        check("lsb overflow", ov0, m_ovf);
        check("msb overflow", ov1, m_ovf);
    endtask

    task automatic apply_stimulus(input bit v, input bit b, input bit r, input bit c);
        @(negedge clk);
        check_output();
        #1;
        din_valid  = v;
        din        = b;
        dout_ready = r;
        clear      = c;
        model_step(v, b, r, c);
    endtask

    // Reset pulse placed between clock edges; outputs must clear without a clock.
    task automatic pulse_reset();
        @(negedge clk);
        #1;
        din_valid  = 1'b0;
        clear      = 1'b0;
        dout_ready = 1'b0;
        rst_n      = 1'b0;
        model_reset();
        #2;
        check("rst lsb dout", dout0, 8'h00);
        check("rst msb dout", dout1, 8'h00);
        check("rst dout_valid", {dv0, dv1}, 2'b00);
        check("rst bit_index", {bi0, bi1}, 6'd0);
        check("rst busy", {busy0, busy1}, 2'b00);
        check("rst overflow", {ov0, ov1}, 2'b00);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_word(input logic [7:0] bits, input bit r);
        for (int k = 0; k < 8; k++) apply_stimulus(1'b1, bits[k], r, 1'b0);
    endtask

    // Monitor: pops the scoreboard whenever a new word is presented.
    initial begin
        logic       pv0, pv1;
        logic [7:0] pd0, pd1;
        pv0 = 1'b0;
        pv1 = 1'b0;
        pd0 = '0;
        pd1 = '0;
        forever begin
            @(negedge clk);
            if (dv0 && !pv0) begin
                if (exp_lsb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL lsb unexpected word: got %0h, expected none", dout0);
                end else begin
                    check("lsb word", dout0, exp_lsb.pop_front());
                end
            end else if (dv0 && pv0) begin
                check("lsb hold", dout0, pd0);
            end
            if (dv1 && !pv1) begin
                if (exp_msb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL msb unexpected word: got %0h, expected none", dout1);
                end else begin
                    check("msb word", dout1, exp_msb.pop_front());
                end
            end else if (dv1 && pv1) begin
                check("msb hold", dout1, pd1);
            end
            pv0 = dv0;
            pv1 = dv1;
            pd0 = dout0;
            pd1 = dout1;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        model_reset();
        pulse_reset();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Arrival order 0,1,1,0,1,1,0,1 held with no consumer.
        send_word(8'b1011_0110, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check("stream lsb dout", dout0, 8'b1011_0110);
        check("stream msb dout", dout1, 8'b0110_1101);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        check("ovf lsb dout kept", dout0, 8'b1011_0110);
        check("ovf set", ov0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back words with the consumer always ready.
        pulse_reset();
        send_word(8'hA5, 1'b1);
        send_word(8'h3C, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);

        // Clear after five bits, then a clean word.
        for (int k = 0; k < 5; k++) apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1);
        send_word(8'h96, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Clear while a word is held must not drop it.
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset after three bits.
        for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
        pulse_reset();
        send_word(8'h4E, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);

        for (int n = 0; n < 800; n++) begin
            apply_stimulus(($urandom % 4) != 0, $urandom % 2, ($urandom % 3) != 0,
                           ($urandom % 25) == 0);
        end

        for (int n = 0; n < 3; n++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("lsb words left", exp_lsb.size(), 0);
        check("msb words left", exp_msb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demultiplexer_1to8_deser.md
DEMULTIPLEXER_1TO8_DESER -- requirements
Module: demultiplexer_1to8_deser

Interface
REQ-001 Parameter: MSB_FIRST, default 0; 0 = first serial bit lands in dout[0], 1 = first bit lands in dout[7].
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: din  input  1  serial data bit.
REQ-005 Port: din_valid  input  1  din is sampled this cycle.
REQ-006 Port: clear  input  1  synchronous abort of the partial word; index returns to 0.
REQ-007 Port: dout  output  8  assembled parallel word.
REQ-008 Port: dout_valid  output  1  dout holds a complete word.
REQ-009 Port: dout_ready  input  1  consumer accepts dout this cycle.
REQ-010 Port: bit_index  output  3  destination select for the next accepted bit.
REQ-011 Port: busy  output  1  partial word in progress (1 to 7 bits held).
REQ-012 Port: overflow  output  1  sticky flag; a bit was dropped.

Function
REQ-013 The block SHALL be the 1-to-8 receiving end of the 8-to-1 serial path: bit k of a word (k = 0..7 in arrival order) is steered to position k, or 7-k when MSB_FIRST=1.
REQ-014 States: IDLE (index 0, no data), COLLECT (1..7 bits held), FULL (dout_valid=1).
REQ-015 IDLE + din_valid -> COLLECT; bit written, index -> 1.
REQ-016 COLLECT + din_valid -> bit written, index +1; on the 8th bit (index 7) the word completes, index wraps to 0, state -> FULL.
REQ-017 dout_valid SHALL assert on the cycle after the 8th accepted bit (latency 1 clk from the last bit edge).
REQ-018 FULL: dout and dout_valid are held stable until dout_ready=1; the word is transferred on the cycle with dout_valid & dout_ready.
REQ-019 FULL + dout_ready + din_valid in the same cycle: the word is released and din becomes bit 0 of the next word (state -> COLLECT, index 1); no bubble.
REQ-020 FULL + !dout_ready + din_valid: the bit is dropped, overflow is set to 1 and stays 1 until reset, and dout is unchanged.
REQ-021 clear=1 discards partial bits and sets index to 0, state IDLE if not FULL; clear SHALL NOT drop a FULL word; clear has priority over din_valid in the same cycle.
REQ-022 Bit positions not yet written in the current word SHALL retain their previous values; dout is meaningful only while dout_valid=1.
REQ-023 din_valid=0 SHALL leave all state unchanged (no idle timeout).
REQ-024 busy=1 exactly in COLLECT; bit_index is a registered output equal to the internal index counter.

Reset
REQ-025 While rst_n=0, regardless of clk: state IDLE, dout=8'h00, dout_valid=0, bit_index=0, busy=0, overflow=0.
REQ-026 Reset asserted mid-word or while FULL SHALL discard all data; the first din_valid after deassertion is bit 0.
REQ-027 Reset deassertion is assumed synchronized externally; the first edge after release behaves as in IDLE.

Structure
REQ-028 Shared package: state enum (IDLE, COLLECT, FULL), WORD_W=8, IDX_W=3.
REQ-029 One sub-module: demux_1to8_dec, a combinational 3-to-8 one-hot write-enable decoder driven by bit_index (inverted when MSB_FIRST=1); the FSM, counter and word register live in the top level.

Verification
REQ-030 Reset, then 8 consecutive din_valid cycles with bits 0,1,1,0,1,1,0,1 in arrival order and MSB_FIRST=0 -> dout=8'b10110110, dout_valid=1 one clk after the 8th bit.
REQ-031 Same stream with MSB_FIRST=1 -> dout=8'b01101101.
REQ-032 Word held with dout_ready=0, then 2 extra din_valid -> overflow=1, dout unchanged; set dout_ready=1 -> dout_valid drops the next cycle.
REQ-033 Back-to-back: 16 bits with dout_ready=1 on the 8th-bit+1 cycle -> two words delivered, no dropped bits, overflow=0.
REQ-034 After 5 bits, assert clear -> bit_index=0, busy=0; the next 8 bits form a clean word.
REQ-035 After 3 bits, pulse rst_n low between clock edges -> all outputs 0 immediately; the subsequent word assembles from bit_index 0.
